// File: rtl/apb_table_regs.sv
// APB slave fronting NUM_TBL RAM-backed tables plus CTRL and ERRCNT registers.
// Wide entries are staged per word and committed to RAM on the last word.
module apb_table_regs #(
  parameter int NUM_TBL   = 2,
  parameter int TBL_DEPTH = 16,
  parameter int ENTRY_W   = 48,
  parameter int RD_LAT    = 1,
  localparam int IDX_W    = $clog2(TBL_DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       psel,
  input  logic                       penable,
  input  logic                       pwrite,
  input  logic [31:0]                paddr,
  input  logic [31:0]                pwdata,
  output logic [31:0]                prdata,
  output logic                       pready,
  output logic                       pslverr,
  output logic [NUM_TBL-1:0]         mem_en,
  output logic                       mem_wr,
  output logic [IDX_W-1:0]           mem_addr,
  output logic [ENTRY_W-1:0]         mem_wdata,
  input  logic [NUM_TBL*ENTRY_W-1:0] mem_rdata
);

  localparam int NWD = (ENTRY_W + 31) / 32;
  localparam int WPE = 1 << $clog2(NWD);
  localparam int WW  = (WPE > 1) ? $clog2(WPE) : 1;
  localparam int TW  = (NUM_TBL > 1) ? $clog2(NUM_TBL) : 1;
  localparam int SW  = WPE * 32;
  localparam int WB  = $clog2(WPE * 4);
  localparam int SB  = $clog2(TBL_DEPTH * WPE * 4);
  localparam logic [31:0] REG_BASE = 32'(NUM_TBL) << SB;

  typedef enum logic [1:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    RESP
  } state_e;

  state_e               state_q;
  logic [TW-1:0]        tbl_q;
  logic [IDX_W-1:0]     idx_q;
  logic [WW-1:0]        w_q;
  logic [1:0]           cnt_q;
  logic [SW-1:0]        wr_stage_q;
  logic [ENTRY_W-1:0]   rd_stage_q;
  logic                 rd_valid_q;
  logic [TW-1:0]        rd_tbl_q;
  logic [IDX_W-1:0]     rd_idx_q;
  logic [15:0]          errcnt_q;
  logic [31:0]          prdata_q;
  logic                 pready_q;
  logic                 pslverr_q;
  logic [NUM_TBL-1:0]   mem_en_q;
  logic                 mem_wr_q;
  logic [IDX_W-1:0]     mem_addr_q;
  logic [ENTRY_W-1:0]   mem_wdata_q;

  logic                 is_tbl;
  logic                 is_ctrl;
  logic                 is_errc;
  logic                 bad;
  logic                 hit;
  logic                 last_w;
  logic [TW-1:0]        t_dec;
  logic [IDX_W-1:0]     idx_dec;
  logic [WW-1:0]        w_dec;
  logic [NUM_TBL-1:0]   t_oh;
  logic [ENTRY_W-1:0]   rd_slice;

  function automatic logic [31:0] word_of(
    input logic [ENTRY_W-1:0] e,
    input logic [WW-1:0]      w
  );
    logic [SW-1:0] p;
    p = SW'(e);
    return p[32*w +: 32];
  endfunction

  // last word comes straight from the bus, earlier words from the stage
  function automatic logic [ENTRY_W-1:0] commit_of(
    input logic [SW-1:0] s,
    input logic [31:0]   d
  );
    logic [SW-1:0] c;
    c = s;
    c[(WPE-1)*32 +: 32] = d;
    return c[ENTRY_W-1:0];
  endfunction

  always_comb begin
    is_tbl   = paddr < REG_BASE;
    is_ctrl  = paddr == REG_BASE;
    is_errc  = paddr == REG_BASE + 32'd4;
    bad      = (paddr[1:0] != 2'b00) ||
               !(is_tbl || is_ctrl || is_errc);
    t_dec    = TW'(paddr >> SB);
    idx_dec  = paddr[WB +: IDX_W];
    w_dec    = WW'(paddr[31:2] & 30'(WPE - 1));
    t_oh     = NUM_TBL'(1) << t_dec;
    last_w   = w_dec == WW'(WPE - 1);
    hit      = rd_valid_q && (rd_tbl_q == t_dec) &&
               (rd_idx_q == idx_dec) && (w_dec != '0);
    rd_slice = mem_rdata[tbl_q*ENTRY_W +: ENTRY_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tbl_q       <= '0;
      idx_q       <= '0;
      w_q         <= '0;
      cnt_q       <= '0;
      wr_stage_q  <= '0;
      rd_stage_q  <= '0;
      rd_valid_q  <= 1'b0;
      rd_tbl_q    <= '0;
      rd_idx_q    <= '0;
      errcnt_q    <= '0;
      prdata_q    <= '0;
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
      mem_en_q    <= '0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      prdata_q    <= '0;
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
      mem_en_q    <= '0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if (state_q == RESP && pslverr_q && errcnt_q != 16'hFFFF)
        errcnt_q <= errcnt_q + 16'd1;
      unique case (state_q)
        IDLE: begin
          if (psel && penable) begin
            tbl_q <= t_dec;
            idx_q <= idx_dec;
            w_q   <= w_dec;
            if (bad) begin
              state_q   <= RESP;
              pready_q  <= 1'b1;
              pslverr_q <= 1'b1;
              prdata_q  <= 32'hBADD_C0DE;
            end else if (is_ctrl) begin
              state_q  <= RESP;
              pready_q <= 1'b1;
              if (pwrite && pwdata[0]) begin
                wr_stage_q <= '0;
                rd_valid_q <= 1'b0;
              end
            end else if (is_errc) begin
              state_q  <= RESP;
              pready_q <= 1'b1;
              if (pwrite) errcnt_q <= '0;
              else prdata_q <= {16'h0, errcnt_q};
            end else if (pwrite) begin
              state_q  <= RESP;
              pready_q <= 1'b1;
              if (last_w) begin
                mem_en_q    <= t_oh;
                mem_wr_q    <= 1'b1;
                mem_addr_q  <= idx_dec;
                mem_wdata_q <= commit_of(wr_stage_q, pwdata);
                wr_stage_q  <= '0;
                if (rd_tbl_q == t_dec && rd_idx_q == idx_dec)
                  rd_valid_q <= 1'b0;
              end else begin
                wr_stage_q[32*w_dec +: 32] <= pwdata;
              end
            end else if (hit) begin
              state_q  <= RESP;
              pready_q <= 1'b1;
              prdata_q <= word_of(rd_stage_q, w_dec);
            end else begin
              state_q    <= RD_ISSUE;
              mem_en_q   <= t_oh;
              mem_addr_q <= idx_dec;
            end
          end
        end
        RD_ISSUE: begin
          state_q <= RD_WAIT;
          cnt_q   <= 2'(RD_LAT - 1);
        end
        RD_WAIT: begin
          if (cnt_q == 2'd0) begin
            state_q    <= RESP;
            rd_stage_q <= rd_slice;
            rd_valid_q <= 1'b1;
            rd_tbl_q   <= tbl_q;
            rd_idx_q   <= idx_q;
            pready_q   <= 1'b1;
            prdata_q   <= word_of(rd_slice, w_q);
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        RESP: state_q <= IDLE;
      endcase
    end
  end

  assign prdata    = prdata_q;
  assign pready    = pready_q;
  assign pslverr   = pslverr_q;
  assign mem_en    = mem_en_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_apb_table_regs.sv
// Bench for apb_table_regs: RAM model, reference model of the register map,
// directed cases plus randomized APB traffic.
module tb_apb_table_regs;

  localparam int NT       = 2;
  localparam int DEPTH    = 16;
  localparam int EW       = 48;
  localparam int RDL      = 2;
  localparam int STRIDE   = 128;
  localparam int REG_BASE = 256;

  typedef struct {
    int         t;
    bit         wr;
    int         idx;
    logic [47:0] data;
  } ev_t;

  logic           clk;
  logic           rst_n;
  logic           psel;
  logic           penable;
  logic           pwrite;
  logic [31:0]    paddr;
  logic [31:0]    pwdata;
  logic [31:0]    prdata;
  logic           pready;
  logic           pslverr;
  logic [NT-1:0]  mem_en;
  logic           mem_wr;
  logic [3:0]     mem_addr;
  logic [EW-1:0]  mem_wdata;
  logic [NT*EW-1:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [EW-1:0] ram [NT][DEPTH];
  logic [EW-1:0] p1 [NT];
  logic [EW-1:0] p2 [NT];
  logic          ram_init;
  logic          mon_en;
  logic [47:0]   last_wdata;
  ev_t           exp_q[$];

  logic [47:0] ref_tbl [NT][DEPTH];
  logic [31:0] m_wr0;
  bit          sv;
  int          st;
  int          si;
  logic [47:0] sd;
  int          m_err;

  apb_table_regs #(
    .NUM_TBL(NT), .TBL_DEPTH(DEPTH), .ENTRY_W(EW), .RD_LAT(RDL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [47:0] init_val(input int t, input int i);
    return {8'(t * 16 + i), 8'hA5, 32'(i * 32'h1111_1111 ^ t * 32'h0F0F_0000)};
  endfunction

  function automatic logic [31:0] ta(input int t, input int idx, input int w);
    return 32'(t * STRIDE + idx * 8 + w * 4);
  endfunction

  // RAM with RDL-cycle read latency
  always @(posedge clk) begin
    if (ram_init) begin
      for (int t = 0; t < NT; t++)
        for (int i = 0; i < DEPTH; i++)
          ram[t][i] <= init_val(t, i);
    end else begin
      for (int t = 0; t < NT; t++)
        if (mem_en[t]) begin
          if (mem_wr) ram[t][mem_addr] <= mem_wdata;
          else p1[t] <= ram[t][mem_addr];
        end
    end
    for (int t = 0; t < NT; t++) p2[t] <= p1[t];
  end
  assign mem_rdata = {p2[1], p2[0]};

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    ev_t ev;
    if (mon_en && rst_n) begin
      if (mem_en != '0) begin
        if (exp_q.size() == 0) begin
          chk("mem_unexpected", 64'(mem_en), 64'd0);
        end else begin
          ev = exp_q.pop_front();
          chk("mem_en", 64'(mem_en), 64'(1 << ev.t));
          chk("mem_wr", 64'(mem_wr), 64'(ev.wr));
          chk("mem_addr", 64'(mem_addr), 64'(ev.idx));
          chk("mem_wdata", 64'(mem_wdata), ev.wr ? 64'(ev.data) : 64'd0);
          chk("mem_phase", 64'(pready), 64'(ev.wr));
          if (mem_wr) last_wdata = mem_wdata;
        end
      end else begin
        chk("mem_idle", {11'd0, mem_wr, mem_addr, mem_wdata}, 64'd0);
      end
    end
  end

  task automatic model_reset();
    m_wr0 = '0;
    sv    = 1'b0;
    m_err = 0;
  endtask

  task automatic model_access(input bit wr, input logic [31:0] a,
                              input logic [31:0] d, output logic [31:0] er,
                              output bit ee, output int el);
    int t, idx, w;
    logic [63:0] full;
    er = '0; ee = 1'b0; el = 1;
    if (a[1:0] != 2'b00 || a > REG_BASE + 4) begin
      er = 32'hBADD_C0DE;
      ee = 1'b1;
      if (m_err < 'hFFFF) m_err++;
    end else if (a == REG_BASE) begin
      if (wr && d[0]) begin m_wr0 = '0; sv = 1'b0; end
    end else if (a == REG_BASE + 4) begin
      if (wr) m_err = 0;
      else er = 32'(m_err);
    end else begin
      t   = int'(a) / STRIDE;
      idx = (int'(a) / 8) % DEPTH;
      w   = (int'(a) / 4) % 2;
      if (wr) begin
        if (w == 1) begin
          full = {d, m_wr0};
          ref_tbl[t][idx] = full[47:0];
          exp_q.push_back('{t, 1'b1, idx, full[47:0]});
          m_wr0 = '0;
          if (sv && st == t && si == idx) sv = 1'b0;
        end else begin
          m_wr0 = d;
        end
      end else begin
        if (!(sv && st == t && si == idx && w != 0)) begin
          sv = 1'b1; st = t; si = idx; sd = ref_tbl[t][idx];
          el = 2 + RDL;
          exp_q.push_back('{t, 1'b0, idx, 48'd0});
        end
        full = {16'h0, sd};
        er = full[w*32 +: 32];
      end
    end
  endtask

  task automatic apb(input bit wr, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic err, output int lat);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    lat = 0;
    @(negedge clk);
    while (!pready && lat < 40) begin
      lat++;
      @(negedge clk);
    end
    rd = prdata; err = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
  endtask

  task automatic do_acc(input bit wr, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd,
                        output int lat);
    logic [31:0] er;
    bit ee;
    int el;
    logic err;
    model_access(wr, a, d, er, ee, el);
    apb(wr, a, d, rd, err, lat);
    chk("latency", 64'(lat), 64'(el));
    chk("prdata", 64'(rd), 64'(er));
    chk("pslverr", 64'(err), 64'(ee));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int lat;
    logic [31:0] er;
    bit ee;
    int el;
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; ram_init = 1'b1; mon_en = 1'b0;
    last_wdata = '0;
    for (int t = 0; t < NT; t++)
      for (int i = 0; i < DEPTH; i++)
        ref_tbl[t][i] = init_val(t, i);
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    ram_init = 1'b0;
    chk("rst_pready", 64'(pready), 64'd0);
    chk("rst_pslverr", 64'(pslverr), 64'd0);
    chk("rst_prdata", 64'(prdata), 64'd0);
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    do_acc(1'b0, REG_BASE + 4, 0, rd, lat);
    chk("rst_errcnt", 64'(rd), 64'd0);

    // entry commit from two words
    do_acc(1'b1, ta(1, 3, 0), 32'h1234_5678, rd, lat);
    do_acc(1'b1, ta(1, 3, 1), 32'h0000_ABCD, rd, lat);
    chk("t1_wdata", 64'(last_wdata), 64'h0000_ABCD_1234_5678);

    do_acc(1'b0, ta(1, 3, 0), 0, rd, lat);
    chk("t2_w0_data", 64'(rd), 64'h1234_5678);
    chk("t2_w0_lat", 64'(lat), 64'd4);
    do_acc(1'b0, ta(1, 3, 1), 0, rd, lat);
    chk("t2_w1_data", 64'(rd), 64'h0000_ABCD);
    chk("t2_w1_lat", 64'(lat), 64'd1);

    // commit to the snapshotted entry forces a refetch
    do_acc(1'b0, ta(1, 3, 0), 0, rd, lat);
    do_acc(1'b1, ta(1, 3, 0), 32'h5555_5555, rd, lat);
    do_acc(1'b1, ta(1, 3, 1), 32'hFF00_0077, rd, lat);
    do_acc(1'b0, ta(1, 3, 1), 0, rd, lat);
    chk("t3_lat", 64'(lat), 64'd4);
    chk("t3_data", 64'(rd), 64'h0000_0077);

    do_acc(1'b0, REG_BASE + 8, 0, rd, lat);
    chk("t4_bad_data", 64'(rd), 64'hBADD_C0DE);
    do_acc(1'b0, REG_BASE + 4, 0, rd, lat);
    chk("t4_errcnt1", 64'(rd), 64'd1);
    force dut.errcnt_q = 16'hFFFD;
    @(posedge clk); #1;
    release dut.errcnt_q;
    m_err = 'hFFFD;
    do_acc(1'b0, REG_BASE + 2, 0, rd, lat);
    do_acc(1'b1, 32'hFFFF_0000, 1, rd, lat);
    do_acc(1'b0, ta(0, 1, 0) + 1, 0, rd, lat);
    do_acc(1'b1, REG_BASE + 12, 7, rd, lat);
    do_acc(1'b0, REG_BASE + 4, 0, rd, lat);
    chk("t4_errcnt_sat", 64'(rd), 64'hFFFF);
    do_acc(1'b1, REG_BASE + 4, 0, rd, lat);
    do_acc(1'b0, REG_BASE + 4, 0, rd, lat);
    chk("t4_errcnt_clr", 64'(rd), 64'd0);

    // stage_clr drops the staged low word
    do_acc(1'b1, ta(0, 5, 0), 32'hDEAD_BEEF, rd, lat);
    do_acc(1'b1, REG_BASE, 32'h1, rd, lat);
    do_acc(1'b1, ta(0, 5, 1), 32'h1, rd, lat);
    chk("t5_wdata", 64'(last_wdata), 64'h0001_0000_0000);

    // reset during RD_WAIT
    do_acc(1'b1, ta(0, 6, 0), 32'hCAFE_F00D, rd, lat);
    do_acc(1'b0, REG_BASE + 16, 0, rd, lat);
    model_access(1'b0, ta(0, 5, 0), 0, er, ee, el);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = ta(0, 5, 0);
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t6_pready", 64'(pready), 64'd0);
    chk("t6_mem_en", 64'(mem_en), 64'd0);
    chk("t6_prdata", 64'(prdata), 64'd0);
    psel = 1'b0; penable = 1'b0; paddr = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t6_quiet", 64'(pready), 64'd0);
    end
    do_acc(1'b0, REG_BASE + 4, 0, rd, lat);
    chk("t6_errcnt", 64'(rd), 64'd0);
    do_acc(1'b0, ta(0, 5, 1), 0, rd, lat);
    chk("t6_miss_lat", 64'(lat), 64'd4);
    do_acc(1'b1, ta(0, 6, 1), 32'h2, rd, lat);
    chk("t6_stage_clr", 64'(last_wdata), 64'h0002_0000_0000);

    for (int n = 0; n < 300; n++) begin
      int r, t, idx, w;
      bit wr;
      logic [31:0] a, d;
      r = $urandom_range(0, 99);
      t = $urandom_range(0, NT - 1);
      idx = $urandom_range(0, 3);
      w = $urandom_range(0, 1);
      wr = 1'($urandom_range(0, 1));
      d = $urandom;
      if (r < 60) a = ta(t, idx, w);
      else if (r < 70) a = REG_BASE;
      else if (r < 80) a = REG_BASE + 4;
      else if (r < 90) a = REG_BASE + 8 + 4 * $urandom_range(0, 7);
      else a = ta(t, idx, w) + $urandom_range(1, 3);
      if (a == REG_BASE + 4 && $urandom_range(0, 3) != 0) wr = 1'b0;
      do_acc(wr, a, d, rd, lat);
      if (r < 60 && !wr && w == 0 && $urandom_range(0, 1) == 1)
        do_acc(1'b0, ta(t, idx, 1), 0, rd, lat);
    end

    repeat (4) @(negedge clk);
    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
